// File: rtl/ranging_sequencer.sv
// Ultrasonic ranging controller: periodic trigger, echo edge timing, rise/width timeout.
// Latency: raw echo edge seen 2 cycles later; meas_valid 1 cycle after detected fall. No backpressure.
// Optional MEDIAN3_EN: echo_cycles presents the median of the last three accepted widths.
module ranging_sequencer #(
  parameter int TRIG_CYCLES   = 120,
  parameter int ECHO_TIMEOUT  = 360000,
  parameter int PERIOD_CYCLES = 720000,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             echo,
  output logic             trig,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             meas_valid,
  output logic             meas_timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  logic             echo_m_q, echo_s_q, echo_d_q;
  logic             trig_q, busy_q, meas_valid_q, meas_timeout_q;
  logic [CNT_W-1:0] per_q, cnt_q, width_q, echo_cycles_q;
  logic [CNT_W-1:0] echo_cycles_d;
  logic             echo_rise, echo_fall;

  assign echo_rise = echo_s_q & ~echo_d_q;
  assign echo_fall = ~echo_s_q & echo_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_m_q <= 1'b0;
      echo_s_q <= 1'b0;
      echo_d_q <= 1'b0;
    end else begin
      echo_m_q <= echo;
      echo_s_q <= echo_m_q;
      echo_d_q <= echo_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      trig_q         <= 1'b0;
      busy_q         <= 1'b0;
      meas_valid_q   <= 1'b0;
      meas_timeout_q <= 1'b0;
      per_q          <= '0;
      cnt_q          <= '0;
      width_q        <= '0;
      echo_cycles_q  <= '0;
    end else begin
      meas_valid_q   <= 1'b0;
      meas_timeout_q <= 1'b0;
      if (per_q != CNT_MAX) per_q <= per_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (enable || start) begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            per_q   <= '0;
          end
        end
        TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            state_q <= WAIT_RISE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_RISE: begin
          // A rise in the final waiting cycle still wins over the timeout.
          if (echo_rise) begin
            state_q <= MEASURE;
            width_q <= CNT_W'(1);
          end else if (cnt_q == TMO_LAST) begin
            state_q        <= HOLDOFF;
            meas_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            state_q       <= HOLDOFF;
            echo_cycles_q <= echo_cycles_d;
            meas_valid_q  <= 1'b1;
          end else if (width_q >= TMO_MAX) begin
            state_q        <= HOLDOFF;
            meas_timeout_q <= 1'b1;
          end else if (echo_s_q && width_q != CNT_MAX) begin
            width_q <= width_q + 1'b1;
          end
        end
        HOLDOFF: begin
          if (per_q == PER_LAST) begin
            if (enable) begin
              state_q <= TRIG;
              trig_q  <= 1'b1;
              cnt_q   <= '0;
              per_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEDIAN3_EN
  logic [CNT_W-1:0] hist0_q, hist1_q;
  logic [1:0]       fill_q;
  logic [CNT_W-1:0] lo_d, hi_d, med_d;
  logic             accept_d;

  // hist0_q is the previous accepted width, hist1_q the one before it.
  always_comb begin
    accept_d      = (state_q == MEASURE) && echo_fall;
    lo_d          = (width_q < hist0_q) ? width_q : hist0_q;
    hi_d          = (width_q < hist0_q) ? hist0_q : width_q;
    med_d         = (hist1_q < lo_d) ? lo_d : ((hist1_q > hi_d) ? hi_d : hist1_q);
    echo_cycles_d = (fill_q == 2'd2) ? med_d : width_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist0_q <= '0;
      hist1_q <= '0;
      fill_q  <= 2'd0;
    end else if (accept_d) begin
      hist1_q <= hist0_q;
      hist0_q <= width_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end
`else
  assign echo_cycles_d = width_q;
`endif

  assign trig         = trig_q;
  assign busy         = busy_q;
  assign meas_valid   = meas_valid_q;
  assign meas_timeout = meas_timeout_q;
  assign echo_cycles  = echo_cycles_q;

endmodule

// File: tb/tb_ranging_sequencer.sv
// Randomized bench for ranging_sequencer with a per-trigger event model and strobe scoreboard.
module tb_ranging_sequencer;
  localparam int TRIG = 4;
  localparam int TMO  = 50;
  localparam int PER  = 200;
  localparam int SYNC = 2;  // raw echo driven in cycle k reaches the edge detector in cycle k+2

  logic        clk = 1'b0;
  logic        reset, enable, start, echo;
  logic        trig, meas_valid, meas_timeout, busy;
  logic [31:0] echo_cycles;

  ranging_sequencer #(
    .TRIG_CYCLES  (TRIG),
    .ECHO_TIMEOUT (TMO),
    .PERIOD_CYCLES(PER),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .echo        (echo),
    .trig        (trig),
    .echo_cycles (echo_cycles),
    .meas_valid  (meas_valid),
    .meas_timeout(meas_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one expected strobe per trigger.
  typedef struct {
    int          kind;  // 1 = valid, 2 = timeout
    int          when;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          hist[$];
  logic [31:0] model_out = 0;

  function automatic void model_reset();
    hist.delete();
    model_out = 0;
  endfunction

  function automatic void model_accept(input int w);
    int s0, s1, s2, mx, mn;
    hist.push_back(w);
    if (hist.size() > 3) void'(hist.pop_front());
    model_out = w;
`ifdef MEDIAN3_EN
    if (hist.size() == 3) begin
      s0 = hist[0]; s1 = hist[1]; s2 = hist[2];
      mx = (s0 > s1) ? s0 : s1; mx = (mx > s2) ? mx : s2;
      mn = (s0 < s1) ? s0 : s1; mn = (mn < s2) ? mn : s2;
      model_out = s0 + s1 + s2 - mx - mn;
    end
`endif
  endfunction

  function automatic void push_expect(input int t0, input int a, input int w, input bit none);
    exp_t e;
    int   r;
    r = a + SYNC;
    if (none || r < TRIG || r >= TRIG + TMO) begin
      e.kind = 2; e.when = t0 + TRIG + TMO; e.val = model_out;
    end else if (w <= TMO) begin
      model_accept(w);
      e.kind = 1; e.when = t0 + r + w + 1; e.val = model_out;
    end else begin
      e.kind = 2; e.when = t0 + r + TMO + 1; e.val = model_out;
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (meas_valid || meas_timeout) begin
      check("strobe_overlap", {31'd0, meas_valid & meas_timeout}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", meas_valid ? 32'd1 : 32'd2, 32'(e.kind));
        check("strobe_cycle", 32'(cyc), 32'(e.when));
        check("echo_cycles", echo_cycles, e.val);
      end
    end
  end

  // Entered at the negedge of the cycle in which trig is expected to have just risen.
  task automatic run_period(input int a, input int w, input bit none, input bit keep_en,
                            input bit extra_start);
    int t0;
    t0 = cyc;
    push_expect(t0, a, w, none);
    for (int k = 0; k < PER; k++) begin
      if (k == 5 && !keep_en) enable = 1'b0;
      if (extra_start) start = (k == 20);
      echo = !none && (k >= a) && (k < a + w);
      check("trig", {31'd0, trig}, (k < TRIG) ? 32'd1 : 32'd0);
      check("busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    echo  = 1'b0;
    start = 1'b0;
  endtask

  int fa[9] = '{13, 0, 10, 10, 10, 10, 51, 2, 0};
  int fw[9] = '{30, 0, 60, 10, 20, 40, 50, 51, 20};
  bit fn[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig", {31'd0, trig}, 32'd0);
    check("rst_echo_cycles", echo_cycles, 32'd0);
    check("rst_valid", {31'd0, meas_valid}, 32'd0);
    check("rst_timeout", {31'd0, meas_timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_trig", {31'd0, trig}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Continuous ranging: directed cases then random ones; enable drops in the last period.
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run_period(fa[i], fw[i], fn[i], 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int mode;
      mode = $urandom_range(0, 3);
      run_period($urandom_range(0, 55), $urandom_range(1, 70), mode == 0, i != 5, 1'b0);
    end
    check("disable_busy", {31'd0, busy}, 32'd0);
    check("disable_trig", {31'd0, trig}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("idle_after_disable", {31'd0, trig}, 32'd0);
    end

    // Single shot with an extra start mid-run that must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_period(5, 7, 1'b0, 1'b0, 1'b1);
    check("single_busy_fall", {31'd0, busy}, 32'd0);
    repeat (10) begin
      check("single_no_retrig", {31'd0, trig}, 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of a measurement.
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      echo = (k >= 10) && (k < 40);
      check("pre_reset_trig", {31'd0, trig}, (k < TRIG) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_trig", {31'd0, trig}, 32'd0);
    check("mid_rst_echo_cycles", echo_cycles, 32'd0);
    check("mid_rst_valid", {31'd0, meas_valid}, 32'd0);
    check("mid_rst_timeout", {31'd0, meas_timeout}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    echo  = 1'b0;
    model_reset();
    @(negedge clk);
    run_period(20, 25, 1'b0, 1'b0, 1'b0);
    check("final_busy", {31'd0, busy}, 32'd0);

    repeat (5) @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
